// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks a PC through the instruction ROM and buffers
// {pc, inst} pairs in a two-entry FIFO for decode, with branch redirect/flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_RUN   = 1'b1;
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];

  logic        running;
  logic        redirect;
  logic        push;
  logic        pop;

  // The two low target bits are dropped: fetch addresses are always word aligned.
  logic        unused_target_bits;
  assign unused_target_bits = ^branch_target_i[1:0];

  assign running    = (state_q == S_RUN);
  assign redirect   = running && branch_flag_i;
  assign id_valid_o = (count_q != 2'd0);
  assign pop        = id_valid_o && id_ready_i;
  assign push       = running && !branch_flag_i && ((count_q != 2'd2) || pop);

  assign rom_ce_o   = push;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = id_valid_o ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign id_inst_o  = id_valid_o ? fifo_inst_q[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      // A redirect wins over a concurrent pop: everything buffered is stale.
      pc_d     = {branch_target_i[31:2], 2'b00};
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_INIT;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pc_q;
      fifo_inst_q[wr_ptr_q] <= rom_inst_i;
    end
  end

endmodule
